// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, memory request handshake, one-word hold buffer and IF/ID register.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
//
//   state | meaning
//   BOOT  | first cycle after reset, no request, memory response ignored
//   FETCH | request outstanding at PCF, waiting for ImemValid
//   HOLD  | word captured under stall, waiting for release, no request
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemRdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] InstrCount,
    output logic [31:0] StallCount
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        available;
    logic        accept;
    logic        capture;
    logic        stall_cycle;
    logic [31:0] word;
    logic [31:0] pc_plus4;
    logic [31:0] pc_redirect;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Redirect outranks every other transition, including the boot cycle.
    always_comb begin
        state_d = state_q;
        if (PCSrcE) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                BOOT:    state_d = FETCH;
                FETCH:   if (capture) state_d = HOLD;
                HOLD:    if (accept) state_d = FETCH;
                default: state_d = BOOT;
            endcase
        end
    end

    always_comb begin
        ImemReq     = (state_q == FETCH);
        available   = ((state_q == FETCH) && ImemValid) || (state_q == HOLD);
        accept      = available && !StallF && !StallD && !PCSrcE;
        capture     = (state_q == FETCH) && ImemValid && (StallF || StallD) && !PCSrcE;
        stall_cycle = ((state_q == FETCH) && !ImemValid) || (state_q == HOLD);
        word        = (state_q == HOLD) ? hold_buf_q : ImemRdata;
    end

    assign pc_plus4    = pc_q + 32'd4;
    assign pc_redirect = PCTargetE & ~32'h0000_0003;

    always_comb begin
        pc_d       = pc_q;
        hold_buf_d = hold_buf_q;
        if (PCSrcE) begin
            pc_d       = pc_redirect;
            hold_buf_d = '0;
        end else if (accept) begin
            pc_d = pc_plus4;
        end else if (capture) begin
            hold_buf_d = ImemRdata;
        end
    end

    always_comb begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = '0;
        ifid_pc4_d   = '0;
        ifid_valid_d = 1'b0;
        if (FlushD) begin
            ifid_valid_d = 1'b0;
        end else if (StallD) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc_d    = ifid_pc_q;
            ifid_pc4_d   = ifid_pc4_q;
            ifid_valid_d = ifid_valid_q;
        end else if (accept) begin
            ifid_instr_d = word;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            hold_buf_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            hold_buf_q   <= hold_buf_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign ImemAddr = pc_q;
    assign InstrD   = ifid_instr_q;
    assign PCD      = ifid_pc_q;
    assign PCPlus4D = ifid_pc4_q;
    assign ValidD   = ifid_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        instr_cnt_d = instr_cnt_q + {31'd0, accept};
        stall_cnt_d = stall_cnt_q + {31'd0, stall_cycle};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign InstrCount = instr_cnt_q;
    assign StallCount = stall_cnt_q;
`else
    logic unused_stall_cycle;
    assign unused_stall_cycle = stall_cycle;
    assign InstrCount = '0;
    assign StallCount = '0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, the bubble encoding (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port StallF  input  1  hold PC, no instruction accepted.
REQ-006 SHALL have port StallD  input  1  hold IF/ID register, no instruction accepted.
REQ-007 SHALL have port FlushD  input  1  load bubble into IF/ID.
REQ-008 SHALL have port PCSrcE  input  1  redirect request from execute.
REQ-009 SHALL have port PCTargetE  input  32  redirect target.
REQ-010 SHALL have port ImemReq  output  1  fetch request to instruction memory.
REQ-011 SHALL have port ImemAddr  output  32  fetch address, equal to PCF.
REQ-012 SHALL have port ImemValid  input  1  ImemRdata valid for current ImemAddr this cycle.
REQ-013 SHALL have port ImemRdata  input  32  fetched instruction word.
REQ-014 SHALL have ports InstrD, PCD, PCPlus4D  output  32 each  IF/ID register contents feeding decode.
REQ-015 SHALL have port ValidD  output  1  InstrD holds a real instruction.
REQ-016 SHALL have ports InstrCount, StallCount  output  32 each  performance counters.

Function
REQ-017 SHALL implement states BOOT, FETCH, HOLD; BOOT -> FETCH unconditionally after one cycle.
REQ-018 SHALL drive ImemReq=1 in FETCH only; 0 in BOOT and HOLD; ImemAddr SHALL stay stable while ImemReq=1 and ImemValid=0.
REQ-019 SHALL define "available" = (FETCH & ImemValid) | HOLD; "accept" = available & !StallF & !StallD & !PCSrcE.
REQ-020 On accept: InstrD<=word (ImemRdata or held buffer), PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1, PCF<=PCF+4, state->FETCH.
REQ-021 In FETCH with ImemValid and (StallF|StallD) and !PCSrcE: word SHALL be captured in a 32-bit hold buffer, state->HOLD, PCF unchanged.
REQ-022 In HOLD, buffer SHALL be released (REQ-020) on first cycle with !StallF & !StallD; no new memory request while in HOLD.
REQ-023 PCSrcE SHALL take priority over everything except reset: PCF<={PCTargetE[31:2],2'b00}, hold buffer discarded, state->FETCH, IF/ID loads bubble unless StallD=1 & FlushD=0.
REQ-024 Bubble SHALL mean InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-025 IF/ID priority per cycle: FlushD -> bubble; else StallD -> hold; else accept -> load; else bubble.
REQ-026 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 Fetch latency SHALL be one cycle from ImemValid to InstrD update when unstalled; sustained throughput one instruction per cycle with ImemValid held high.

Reset
REQ-028 With reset_n=0 at a clock edge: PCF=RESET_PC, state=BOOT, ImemReq=0, IF/ID=bubble, hold buffer cleared, counters=0.
REQ-029 Reset mid-fetch or in HOLD SHALL abandon the outstanding word; any ImemValid in the BOOT cycle SHALL be ignored.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: InstrCount SHALL increment on each accept, StallCount on each cycle in (FETCH & !ImemValid) or HOLD; both wrap modulo 2^32.
REQ-031 Macro FETCH_PERF_CNT_EN undefined: InstrCount and StallCount SHALL be constant 0 and no counter registers implemented.

Verification
REQ-032 Reset release, ImemValid=1 always, Rdata=32'h00500093: BOOT 1 cycle, then InstrD=32'h00500093, PCD=0, ValidD=1; next PCD=4, 8, ...
REQ-033 ImemValid low 3 cycles at PC=0x10: ImemAddr held 0x10, ValidD=0 bubbles, StallCount +3 (macro on).
REQ-034 StallD=StallF=1 for 2 cycles as word arrives at PC=0x20: state HOLD, ImemReq=0, IF/ID held; after release InstrD=that word, PCD=0x20, next ImemAddr=0x24.
REQ-035 PCSrcE=1, PCTargetE=32'h0000_0103, FlushD=1 while in HOLD: buffer dropped, next ImemAddr=0x100, ValidD=0, next accepted PCD=0x100.
REQ-036 RESET_PC=32'hFFFF_FFFC: first PCD=32'hFFFF_FFFC, PCPlus4D=0, next PCD=0; reset_n=0 mid-sequence returns ImemAddr to RESET_PC.
